stack_cmd_master: RTL
=====================

// Module: stack_cmd_master
// PURPOSE
//  Initiator for the 8x8 LIFO stack cmd interface. Turns host push/pop/clear requests (valid/ready)
//  into single-cycle stack commands and respects the stack's posedge/negedge flag timing. Returns a
//  one-cycle response with popped data and the error status, and keeps a shadow occupancy count.
//  Sits between a host datapath and one stack instance. Clears the stack after every reset.
// PARAMETERS
//  DW     8  data width of req_data, stk_din, stk_dout and rsp_data
//  DEPTH  8  stack capacity; level saturates at DEPTH
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  req_valid  in   1      host request valid
//  req_ready  out  1      controller idle and able to accept a request
//  req_op     in   2      00 nop, 01 clear, 10 push, 11 pop (same encoding as stack cmd)
//  req_data   in   DW     push data; sampled on acceptance
//  rsp_valid  out  1      one-cycle response pulse; there is no backpressure
//  rsp_data   out  DW     popped data; 0 for non-pop or errored ops
//  rsp_err    out  1      stack reported an error for this op
//  level      out  4      shadow occupancy, 0..DEPTH
//  stk_cmd    out  2      stack command, registered
//  stk_din    out  DW     stack push data, registered
//  stk_dout   in   DW     stack data_out; updates at posedge
//  stk_full   in   1      stack full flag; updates at negedge; monitor only
//  stk_empty  in   1      stack empty flag; updates at negedge; monitor only
//  stk_error  in   1      stack error flag; valid from the negedge after the cmd is sampled until the next negedge
// BEHAVIOUR
//  Reset values (async, immediate): state=INIT, stk_cmd=00, stk_din=0, req_ready=0,
//   rsp_valid=0, rsp_data=0, rsp_err=0, level=0, op_q=00, err_q=0, init_q=1.
//  FSM states: INIT, IDLE, ISSUE, ERRS, DATS. All outputs are registered.
//  INIT: at the first posedge with rst_n high, drive stk_cmd<=01, op_q<=01, then go to ISSUE.
//  IDLE: req_ready=1. On req_valid&&req_ready at posedge A:
//   stk_cmd<=req_op, stk_din<=req_data, op_q<=req_op, req_ready<=0, next state ISSUE.
//  ISSUE (posedge A+1, where the stack samples cmd): stk_cmd<=00, go to ERRS.
//  ERRS (posedge A+2): err_q<=stk_error, go to DATS. Sample here because the stack drops the flag
//   at negedge A+2.
//  DATS (posedge A+3): go to IDLE and set req_ready<=1.
//   If init_q=1: init_q<=0, no rsp_valid.
//   Else: rsp_valid<=1 for exactly one cycle.
//   rsp_err<=err_q, forced to 0 for op 00 and op 01.
//   rsp_data<=(op_q==11 && !err_q) ? stk_dout : 0.
//  Latency: rsp_valid is high in the cycle after posedge A+3. Throughput is one op per 4 cycles.
//   req_ready first rises at posedge 4 after reset release.
//  level is updated at DATS: op 01 -> 0; op 10 && !err_q -> level+1, saturating at DEPTH;
//   op 11 && !err_q -> level-1, floor 0; otherwise unchanged.
//  No local full/empty pre-check: every request goes to the stack, and the stack error decides
//   the response.
//  req_valid while req_ready=0 is ignored; the host must hold it.
//  req_valid held high continuously -> a new op is accepted at every IDLE.
//  Reset mid-operation -> the op is abandoned, no rsp_valid, INIT re-clears the stack.
//  Unused/reserved: none. op 00 runs the full 4-cycle sequence with stk_cmd=00.
// TESTING
//  1 Release reset -> stk_cmd=01 for exactly one cycle after posedge 1, req_ready rises at posedge 4,
//    rsp_valid never pulses, level=0.
//  2 Push 0xA5 accepted at posedge A -> stk_cmd=10 and stk_din=A5 for cycle A..A+1;
//    rsp_valid at A+3 with rsp_err=0, rsp_data=00; level=1.
//  3 Push 11,22,33 then pop x3 -> rsp_data 33,22,11, all rsp_err=0, level 3->0.
//  4 Pop right after clear -> rsp_err=1, rsp_data=00, level stays 0.
//  5 Push x9 after clear -> pushes 1-8 report rsp_err=0, push 9 reports rsp_err=1, level=8.
//  6 rst_n low during DATS of a push -> outputs reset at once, no rsp_valid,
//    CLEAR reissued after release, level=0.

Source files
------------

// File: rtl/stack_cmd_master.sv
// Host-side initiator for the 8x8 LIFO stack: one request becomes one single-cycle stack command,
// followed by a one-cycle response carrying popped data, error status and a shadow occupancy count.
module stack_cmd_master #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [3:0]    level,
    output logic [1:0]    stk_cmd,
    output logic [DW-1:0] stk_din,
    input  logic [DW-1:0] stk_dout,
    input  logic          stk_full,
    input  logic          stk_empty,
    input  logic          stk_error
);

    // state | meaning
    // INIT  | first cycle out of reset, launch the stack clear
    // IDLE  | req_ready high, waiting for a host request
    // ISSUE | stack samples the command this edge; return cmd to nop
    // ERRS  | capture stk_error before the stack drops it at the next negedge
    // DATS  | build the response, update level, reopen for requests
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_ERRS, S_DATS} state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b11;
    localparam logic [3:0] LEVEL_MAX = 4'(DEPTH);

    state_t        state, state_nxt;
    logic [1:0]    op_q, op_q_nxt;
    logic          err_q, err_q_nxt;
    logic          init_q, init_q_nxt;
    logic [1:0]    stk_cmd_nxt;
    logic [DW-1:0] stk_din_nxt;
    logic          req_ready_nxt;
    logic          rsp_valid_nxt;
    logic [DW-1:0] rsp_data_nxt;
    logic          rsp_err_nxt;
    logic [3:0]    level_nxt;

    // The full/empty flags are observation-only; the stack error alone decides each response.
    logic unused_flags;
    assign unused_flags = stk_full ^ stk_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            stk_cmd   <= OP_NOP;
            stk_din   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            level     <= 4'd0;
            op_q      <= OP_NOP;
            err_q     <= 1'b0;
            init_q    <= 1'b1;
        end else begin
            state     <= state_nxt;
            stk_cmd   <= stk_cmd_nxt;
            stk_din   <= stk_din_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            level     <= level_nxt;
            op_q      <= op_q_nxt;
            err_q     <= err_q_nxt;
            init_q    <= init_q_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = S_ISSUE;
            S_IDLE:  if (req_valid && req_ready) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_ERRS;
            S_ERRS:  state_nxt = S_DATS;
            S_DATS:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        stk_cmd_nxt   = stk_cmd;
        stk_din_nxt   = stk_din;
        req_ready_nxt = req_ready;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        level_nxt     = level;
        op_q_nxt      = op_q;
        err_q_nxt     = err_q;
        init_q_nxt    = init_q;
        case (state)
            S_INIT: begin
                stk_cmd_nxt = OP_CLR;
                op_q_nxt    = OP_CLR;
            end
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    stk_cmd_nxt   = req_op;
                    stk_din_nxt   = req_data;
                    op_q_nxt      = req_op;
                    req_ready_nxt = 1'b0;
                end
            end
            S_ISSUE: stk_cmd_nxt = OP_NOP;
            S_ERRS:  err_q_nxt   = stk_error;
            S_DATS: begin
                req_ready_nxt = 1'b1;
                if (init_q) init_q_nxt    = 1'b0;
                else        rsp_valid_nxt = 1'b1;
                rsp_err_nxt  = (op_q == OP_PUSH || op_q == OP_POP) ? err_q : 1'b0;
                rsp_data_nxt = (op_q == OP_POP && !err_q) ? stk_dout : '0;
                case (op_q)
                    OP_CLR:  level_nxt = 4'd0;
                    OP_PUSH: if (!err_q && level != LEVEL_MAX) level_nxt = level + 4'd1;
                    OP_POP:  if (!err_q && level != 4'd0)      level_nxt = level - 4'd1;
                    default: level_nxt = level;
                endcase
            end
            default: ;
        endcase
    end

endmodule
